fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. It owns the program counter and fetches 24-bit instruction words from instruction memory through a req/ack handshake. It presents each word to the decoder for exactly one issue window and applies the decoder's increment, jump-load and finish controls to the PC.

---
 rtl/fetch_if.sv | 25 ++
 rtl/fetch_unit.sv | 72 +++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory and decoder handshake bundle for the fetch stage
interface fetch_if #(
  parameter int PC_W    = 19,
  parameter int INSTR_W = 24
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] INSTRUCTION;
  logic               instr_valid;
  logic               advance;
  logic               inc_pc;
  logic               load_pc;
  logic [INSTR_W-1:0] pc_load_val;
  logic               finish;
  modport master (
    output imem_req, imem_addr, INSTRUCTION, instr_valid,
    input  imem_ack, imem_rdata, advance, inc_pc, load_pc, pc_load_val, finish
  );
  modport slave (
    input  imem_req, imem_addr, INSTRUCTION, instr_valid,
    output imem_ack, imem_rdata, advance, inc_pc, load_pc, pc_load_val, finish
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction fetch stage; optional ack timeout via FETCH_TIMEOUT_EN
module fetch_unit #(
  parameter int PC_W        = 19,
  parameter int INSTR_W     = 24,
  parameter int RESET_PC    = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  fetch_if.master         bus,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fetch_err
);
`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, REQ, ISSUE, HALT, ERR} state_t;
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) < 8) ? 8 : $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic          expired;
  assign expired = (cnt == CW'(TIMEOUT_CYC - 1));
  // Ack wait counter: runs only while waiting in REQ
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else        cnt <= (state == REQ && !bus.imem_ack) ? cnt + 1'b1 : '0;
`else
  typedef enum logic [2:0] {IDLE, REQ, ISSUE, HALT} state_t;
`endif
  state_t             state, nxt;
  logic [INSTR_W-1:0] ir;
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  // Next-state logic; ack takes priority over an expiring timeout
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? REQ : IDLE;
`ifdef FETCH_TIMEOUT_EN
      REQ:     nxt = bus.imem_ack ? ISSUE : expired ? ERR : REQ;
`else
      REQ:     nxt = bus.imem_ack ? ISSUE : REQ;
`endif
      ISSUE:   nxt = !bus.advance ? ISSUE : bus.finish ? HALT : REQ;
      default: nxt = state;
    endcase
  end
  // Captured word and PC update on retirement of the issued word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= PC_W'(RESET_PC);
      ir <= '0;
    end else begin
      if (state == REQ && bus.imem_ack) ir <= bus.imem_rdata;
      if (state == ISSUE && bus.advance && !bus.finish)
        pc <= bus.load_pc ? bus.pc_load_val[PC_W-1:0] : bus.inc_pc ? pc + 1'b1 : pc;
    end
  // Outputs decoded from state; the word reads NOP outside ISSUE
  always_comb begin
    bus.imem_req    = (state == REQ);
    bus.imem_addr   = pc;
    bus.instr_valid = (state == ISSUE);
    bus.INSTRUCTION = (state == ISSUE) ? ir : '0;
    halted          = (state == HALT);
`ifdef FETCH_TIMEOUT_EN
    fetch_err       = (state == ERR);
`else
    fetch_err       = 1'b0;
`endif
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a PC/memory reference model
module tb_fetch_unit;
  localparam int PC_W = 19;
  localparam int INSTR_W = 24;
`ifdef FETCH_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  logic clk = 0, rst_n = 0, start = 0;
  logic [PC_W-1:0] pc;
  logic halted, fetch_err;
  logic [PC_W-1:0] exp_pc;
  int checks = 0, errors = 0;
  fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus();
  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.master),
    .pc(pc), .halted(halted), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [INSTR_W-1:0] word_at(input logic [PC_W-1:0] a);
    if (a == 0) return 24'h300005;
    if (a == 1) return 24'h400000;
    return {a[4:0], a} ^ 24'h5A3C96;
  endfunction
  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", bus.imem_req, 1);
      chk("wait_addr", bus.imem_addr, exp_pc);
      chk("wait_valid", bus.instr_valid, 0);
      chk("wait_instr", bus.INSTRUCTION, 0);
      tick();
    end
    chk("req", bus.imem_req, 1);
    chk("addr", bus.imem_addr, exp_pc);
    bus.imem_ack = 1;
    bus.imem_rdata = word_at(exp_pc);
    tick();
    bus.imem_ack = 0;
    bus.imem_rdata = 24'($urandom);
    chk("valid", bus.instr_valid, 1);
    chk("instr", bus.INSTRUCTION, word_at(exp_pc));
    chk("req_in_issue", bus.imem_req, 0);
  endtask
  task automatic issue(input int dly, input bit inc, input bit ld, input logic [23:0] val, input bit fin);
    logic [INSTR_W-1:0] w;
    w = word_at(exp_pc);
    for (int i = 0; i < dly; i++) begin
      bus.imem_ack = 1'($urandom);
      bus.imem_rdata = 24'($urandom);
      bus.inc_pc = 1'($urandom);
      bus.load_pc = 1'($urandom);
      bus.finish = 1'($urandom);
      start = 1'($urandom);
      tick();
      chk("hold_instr", bus.INSTRUCTION, w);
      chk("hold_valid", bus.instr_valid, 1);
    end
    bus.imem_ack = 0;
    start = 0;
    bus.advance = 1;
    bus.inc_pc = inc;
    bus.load_pc = ld;
    bus.pc_load_val = val;
    bus.finish = fin;
    if (!fin) exp_pc = ld ? val[PC_W-1:0] : inc ? PC_W'((int'(exp_pc) + 1) % (1 << PC_W)) : exp_pc;
    tick();
    bus.advance = 0;
    bus.inc_pc = 0;
    bus.load_pc = 0;
    bus.finish = 0;
    chk("pc", pc, exp_pc);
    chk("valid_clr", bus.instr_valid, 0);
    chk("instr_clr", bus.INSTRUCTION, 0);
    chk("halted", halted, fin);
    chk("req_next", bus.imem_req, !fin);
    if (!fin) chk("addr_next", bus.imem_addr, exp_pc);
  endtask
  initial begin
    bus.imem_ack = 0; bus.imem_rdata = 0; bus.advance = 0;
    bus.inc_pc = 0; bus.load_pc = 0; bus.pc_load_val = 0; bus.finish = 0;
    exp_pc = 0;
    tick();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.INSTRUCTION, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", fetch_err, 0);
    rst_n = 1;
    bus.imem_ack = 1;
    bus.advance = 1;
    tick();
    tick();
    bus.imem_ack = 0;
    bus.advance = 0;
    chk("idle_req", bus.imem_req, 0);
    chk("idle_valid", bus.instr_valid, 0);
    start = 1;
    tick();
    start = 0;
    fetch(0);
    issue(1, 1, 0, 0, 0);
    fetch(0);
    issue(0, 1, 0, 0, 0);
    chk("pc_two", pc, 2);
    fetch(0);
    issue(2, 1, 1, 24'h00002A, 0);
    chk("jump_addr", bus.imem_addr, 19'h2A);
    fetch(0);
    issue(0, 0, 1, 24'hF7FFFF, 0);
    fetch(0);
    issue(0, 1, 0, 0, 0);
    chk("wrap_pc", pc, 0);
    fetch(3);
    issue(0, 0, 0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      fetch($urandom_range(0, 3));
      issue($urandom_range(0, 2), 1'($urandom), 1'($urandom), 24'($urandom), 0);
    end
    fetch(0);
    issue(0, 0, 1, 24'h000005, 0);
    fetch(1);
    issue(1, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_flag", halted, 1);
      chk("halt_pc", pc, 5);
      chk("halt_req", bus.imem_req, 0);
      chk("halt_instr", bus.INSTRUCTION, 0);
    end
    start = 1;
    tick();
    start = 0;
    tick();
    chk("halt_start_req", bus.imem_req, 0);
    chk("halt_start_flag", halted, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    exp_pc = 0;
    chk("rerst_halted", halted, 0);
    chk("rerst_pc", pc, 0);
    start = 1;
    tick();
    start = 0;
    fetch(0);
    issue(0, 0, 1, 24'h000123, 0);
    chk("midreq_req", bus.imem_req, 1);
    rst_n = 0;
    #1;
    exp_pc = 0;
    chk("async_req", bus.imem_req, 0);
    chk("async_pc", pc, 0);
    chk("async_valid", bus.instr_valid, 0);
    chk("async_instr", bus.INSTRUCTION, 0);
    tick();
    bus.imem_ack = 1;
    bus.imem_rdata = 24'hABCDEF;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_ack_req", bus.imem_req, 0);
      chk("late_ack_valid", bus.instr_valid, 0);
      chk("late_ack_instr", bus.INSTRUCTION, 0);
      chk("late_ack_pc", pc, 0);
    end
    bus.imem_ack = 0;
    start = 1;
    tick();
    start = 0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      chk("to_wait_req", bus.imem_req, 1);
      chk("to_wait_err", fetch_err, 0);
      tick();
    end
    chk("to_last_req", bus.imem_req, 1);
    tick();
    chk("to_err", fetch_err, 1);
    chk("to_req", bus.imem_req, 0);
    chk("to_valid", bus.instr_valid, 0);
    bus.imem_ack = 1;
    start = 1;
    tick();
    tick();
    chk("err_sticky", fetch_err, 1);
    chk("err_req", bus.imem_req, 0);
    bus.imem_ack = 0;
    start = 0;
`else
    for (int i = 0; i < 60; i++) begin
      chk("noto_req", bus.imem_req, 1);
      chk("noto_err", fetch_err, 0);
      tick();
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
